pipe_isram: RTL and testbench

PIPE_ISRAM -- requirements
Module: pipe_isram

---
 rtl/pipe_isram.sv | 153 +++++++++++++++
 tb/tb_pipe_isram.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_isram.sv
// Instruction SRAM behind an AXI-lite read-only port, with a side preload write port.
// One outstanding read; response appears LATENCY wait cycles after the AR handshake.
module pipe_isram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
    parameter int                    DEPTH      = 4096,
    parameter int                    LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    input  logic                  rready_i,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_wdata_i,
    output logic [1:0]            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // arready_o is high only in IDLE, rvalid_o only in RESP, and R data is held until taken.

    localparam int                  IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(4 * DEPTH);
    localparam logic [3:0]          LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic                    accept;
    logic                    capture;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   rd_off;
    logic                    rd_in;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [1:0]              rd_resp;

    logic [ADDR_WIDTH-1:0]   ld_off;
    logic                    ld_hit;
    logic [IDX_W-1:0]        ld_idx;

    // With zero latency the response is captured on the handshake edge itself,
    // so the live address is decoded instead of the registered one.
    assign rd_addr = (state_q == IDLE) ? araddr_i : addr_q;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign rd_in   = (rd_addr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
    assign rd_idx  = rd_off[IDX_W+1:2];

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (!rd_in) begin
            rd_resp = RESP_DECERR;
        end else if (rd_addr[1:0] != 2'b00) begin
            rd_resp = RESP_SLVERR;
        end else begin
            rd_word = mem[rd_idx];
        end
    end

    assign ld_off = ld_addr_i - BASE_ADDR;
    assign ld_idx = ld_off[IDX_W+1:2];
    assign ld_hit = ld_we_i && (ld_addr_i >= BASE_ADDR) && ({1'b0, ld_off} < SPAN)
                    && (ld_addr_i[1:0] == 2'b00);

    // Nonblocking write keeps a same-edge read on the old word.
    always_ff @(posedge clk_i) begin
        if (ld_hit) begin
            mem[ld_idx] <= ld_wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (arvalid_i) begin
                    accept = 1'b1;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        capture = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    capture = 1'b1;
                end
            end
            RESP: begin
                if (rready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= araddr_i;
                cnt_q  <= LAT_LOAD;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

    assign arready_o   = (state_q == IDLE);
    assign rvalid_o    = (state_q == RESP);
    assign rdata_o     = rdata_q;
    assign rresp_o     = rresp_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_isram.sv
// Directed bench for pipe_isram: one instance with LATENCY=1, one with LATENCY=0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_isram;

  logic clk;
  logic rst;

  logic [31:0] ar_addr1, ld_addr1, ld_data1, rdata1;
  logic        ar_valid1, r_ready1, ld_we1, arready1, rvalid1;
  logic [1:0]  rresp1, state1;

  logic [31:0] ar_addr0, ld_addr0, ld_data0, rdata0;
  logic        ar_valid0, r_ready0, ld_we0, arready0, rvalid0;
  logic [1:0]  rresp0, state0;

  int checks;
  int failures;

  pipe_isram #(.LATENCY(1)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .araddr_i   (ar_addr1),
    .arvalid_i  (ar_valid1),
    .arready_o  (arready1),
    .rvalid_o   (rvalid1),
    .rdata_o    (rdata1),
    .rresp_o    (rresp1),
    .rready_i   (r_ready1),
    .ld_we_i    (ld_we1),
    .ld_addr_i  (ld_addr1),
    .ld_wdata_i (ld_data1),
    .dbg_state_o(state1)
  );

  pipe_isram #(.LATENCY(0)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .araddr_i   (ar_addr0),
    .arvalid_i  (ar_valid0),
    .arready_o  (arready0),
    .rvalid_o   (rvalid0),
    .rdata_o    (rdata0),
    .rresp_o    (rresp0),
    .rready_i   (r_ready0),
    .ld_we_i    (ld_we0),
    .ld_addr_i  (ld_addr0),
    .ld_wdata_i (ld_data0),
    .dbg_state_o(state0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload1(input logic [31:0] addr, input logic [31:0] data);
    ld_we1 = 1'b1;
    ld_addr1 = addr;
    ld_data1 = data;
    @(negedge clk);
    ld_we1 = 1'b0;
  endtask

  // One LATENCY=1 read; optional stall of `hold` cycles and optional preload
  // to the same word timed onto the RESP-entry edge.
  task automatic read1(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic [1:0] exp_resp, input int hold, input bit do_ld,
                       input logic [31:0] new_data);
    check({tag, "_arready"}, 32'(arready1), 32'd1);
    ar_valid1 = 1'b1;
    ar_addr1 = addr;
    @(negedge clk);
    ar_valid1 = 1'b0;
    ar_addr1 = 32'h0;
    check({tag, "_wait_rvalid"}, 32'(rvalid1), 32'd0);
    check({tag, "_wait_state"}, 32'(state1), 32'd1);
    if (do_ld) begin
      ld_we1 = 1'b1;
      ld_addr1 = addr;
      ld_data1 = new_data;
    end
    @(negedge clk);
    ld_we1 = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
    check({tag, "_rdata"}, rdata1, exp_data);
    check({tag, "_rresp"}, 32'(rresp1), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      ar_valid1 = 1'b1;
      ar_addr1 = 32'h80000004;
      @(negedge clk);
      check({tag, "_hold_rvalid"}, 32'(rvalid1), 32'd1);
      check({tag, "_hold_rdata"}, rdata1, exp_data);
      check({tag, "_hold_rresp"}, 32'(rresp1), 32'(exp_resp));
      check({tag, "_hold_arready"}, 32'(arready1), 32'd0);
    end
    ar_valid1 = 1'b0;
    r_ready1 = 1'b1;
    @(negedge clk);
    r_ready1 = 1'b0;
    check({tag, "_done_rvalid"}, 32'(rvalid1), 32'd0);
    check({tag, "_done_arready"}, 32'(arready1), 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    {ar_valid1, r_ready1, ld_we1, ar_valid0, r_ready0, ld_we0} = '0;
    {ar_addr1, ld_addr1, ld_data1, ar_addr0, ld_addr0, ld_data0} = '0;

    #3;
    check("rst_arready1", 32'(arready1), 32'd1);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rresp1", 32'(rresp1), 32'd0);
    check("rst_state1", 32'(state1), 32'd0);
    check("rst_arready0", 32'(arready0), 32'd1);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=0 instance memory: word i holds 0x1000+i
    for (int i = 0; i < 4; i++) begin
      ld_we0 = 1'b1;
      ld_addr0 = 32'h80000000 + 32'(4 * i);
      ld_data0 = 32'h00001000 + 32'(i);
      @(negedge clk);
    end
    ld_we0 = 1'b0;

    preload1(32'h80000000, 32'h00000413);
    preload1(32'h80000004, 32'h11111111);
    preload1(32'h80000008, 32'h22222222);
    preload1(32'h80003FFC, 32'hDEADBEEF);
    preload1(32'h80000006, 32'h00000BAD);  // unaligned, must be dropped
    preload1(32'h80004000, 32'h00000BAD);  // out of range, must be dropped

    read1("first", 32'h80000000, 32'h00000413, 2'b00, 5, 1'b0, 32'h0);
    read1("word1", 32'h80000004, 32'h11111111, 2'b00, 0, 1'b0, 32'h0);
    read1("below", 32'h7FFFFFFC, 32'h00000000, 2'b11, 0, 1'b0, 32'h0);
    read1("above", 32'h80004000, 32'h00000000, 2'b11, 0, 1'b0, 32'h0);
    read1("unal", 32'h80000002, 32'h00000000, 2'b10, 0, 1'b0, 32'h0);
    read1("unal_oor", 32'h80004001, 32'h00000000, 2'b11, 0, 1'b0, 32'h0);
    read1("top", 32'h80003FFC, 32'hDEADBEEF, 2'b00, 0, 1'b0, 32'h0);
    read1("raw_old", 32'h80000008, 32'h22222222, 2'b00, 0, 1'b1, 32'h33333333);
    read1("raw_new", 32'h80000008, 32'h33333333, 2'b00, 0, 1'b0, 32'h0);

    // reset while in WAIT
    ar_valid1 = 1'b1;
    ar_addr1 = 32'h80000004;
    @(negedge clk);
    ar_valid1 = 1'b0;
    check("rstw_state_pre", 32'(state1), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_rvalid", 32'(rvalid1), 32'd0);
    check("rstw_state", 32'(state1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstw_no_beat", 32'(rvalid1), 32'd0);
      check("rstw_arready", 32'(arready1), 32'd1);
    end
    read1("after_rst", 32'h80000000, 32'h00000413, 2'b00, 0, 1'b0, 32'h0);

    // LATENCY=0 back-to-back with rready tied high: one beat every two cycles
    r_ready0 = 1'b1;
    ar_valid0 = 1'b1;
    ar_addr0 = 32'h80000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_rvalid", 32'(rvalid0), 32'd1);
      check("b2b_rdata", rdata0, 32'h00001000 + 32'(i));
      check("b2b_rresp", 32'(rresp0), 32'd0);
      check("b2b_arready_busy", 32'(arready0), 32'd0);
      if (i == 3) ar_valid0 = 1'b0;
      else ar_addr0 = 32'h80000000 + 32'(4 * (i + 1));
      @(negedge clk);
      check("b2b_gap_rvalid", 32'(rvalid0), 32'd0);
      check("b2b_gap_arready", 32'(arready0), 32'd1);
    end
    r_ready0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
